// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline datapath.
package mips_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned RW_DEF = 5;

    localparam logic [2:0] ALU_ADDU  = 3'b000;
    localparam logic [2:0] ALU_SUBU  = 3'b001;
    localparam logic [2:0] ALU_ORI   = 3'b010;
    localparam logic [2:0] ALU_LOAD  = 3'b011;
    localparam logic [2:0] ALU_STORE = 3'b100;
    localparam logic [2:0] ALU_BEQ   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_ctr;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_ctr:    ALU_ADDU
    };

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: EX/MEM over MEM/WB over stored value; r0 never bypassed.
module fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] stored,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_dst,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd_data
);

    logic hit_exm;
    logic hit_wb;

    assign hit_exm = exm_reg_write && (exm_dst != '0) && (exm_dst == src);
    assign hit_wb  = wb_reg_write  && (wb_dst  != '0) && (wb_dst  == src);

    always_comb begin
        fwd_data = stored;
        if (hit_exm)     fwd_data = exm_result;
        else if (hit_wb) fwd_data = wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic [2:0]    id_alu_ctr,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_dst,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctr,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg
);

    ex_ctrl_t      ctrl_q;
    ex_ctrl_t      id_ctrl;
    logic [RW-1:0] rs_q, rt_q, dst_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] rs_cap, rt_cap;
    logic [DW-1:0] rs_fwd, rt_fwd;

    assign id_ctrl = '{
        valid:      id_valid,
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        alu_src:    id_alu_src,
        alu_ctr:    id_alu_ctr
    };

    // Immediate extension depends on the opcode class.
    always_comb begin
        imm_ext = DW'($signed(id_imm16));
        case (id_alu_ctr)
            ALU_ORI: imm_ext = DW'(id_imm16);
            ALU_LUI: imm_ext = DW'({id_imm16, 16'h0000});
            default: imm_ext = DW'($signed(id_imm16));
        endcase
    end

    // Same-cycle regfile write is not yet visible in the read data.
    assign rs_cap = (wb_reg_write && (wb_dst != '0) && (wb_dst == id_rs)) ? wb_data : id_rs_data;
    assign rt_cap = (wb_reg_write && (wb_dst != '0) && (wb_dst == id_rt)) ? wb_data : id_rt_data;

    assign stall = ctrl_q.valid && ctrl_q.mem_read && (rt_q != '0) && id_valid &&
                   ((rt_q == id_rs) || (id_uses_rt && (rt_q == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (flush || stall) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= id_ctrl;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            dst_q     <= id_reg_dst ? id_rd : id_rt;
            rs_data_q <= rs_cap;
            rt_data_q <= rt_cap;
            imm_q     <= imm_ext;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src           (rs_q),
        .stored        (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_dst       (exm_dst),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .fwd_data      (rs_fwd)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src           (rt_q),
        .stored        (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_dst       (exm_dst),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .fwd_data      (rt_fwd)
    );

    assign alu_a         = rs_fwd;
    assign ex_store_data = rt_fwd;
    assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign alu_ctr       = ctrl_q.alu_ctr;
    assign ex_valid      = ctrl_q.valid;
    assign ex_dst        = dst_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, immediates, forwarding, load-use, flush, r0 guard.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic [2:0]  id_alu_ctr;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_dst;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_ctr;
    logic [4:0]  ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
        .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctr(alu_ctr), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm16 = 0; id_alu_ctr = 3'b000;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; flush = 0;
    endtask

    task automatic clear_bypass();
        exm_reg_write = 0; exm_dst = 0; exm_result = 0;
        wb_reg_write = 0; wb_dst = 0; wb_data = 0;
    endtask

    // LOAD rt <- mem[rs + imm]
    task automatic drive_load(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        idle_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_imm16 = imm; id_alu_ctr = 3'b011;
        id_alu_src = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    // ADDU rd <- rs + rt
    task automatic drive_addu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rsd, input logic [31:0] rtd, input logic uses_rt);
        idle_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_alu_ctr = 3'b000; id_reg_dst = 1; id_reg_write = 1; id_uses_rt = uses_rt;
    endtask

    task automatic test_reset();
        drive_load(5'd1, 5'd8, 16'h0004);
        step();
        drive_addu(5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_prestall stall=%b exp=1", stall); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall stall=%b exp=0", stall); end
        checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_to_reg !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl v=%b mr=%b rw=%b m2r=%b exp=0", ex_valid, ex_mem_read, ex_reg_write, ex_mem_to_reg); end
        checks++; if (alu_ctr !== 3'b000 || ex_dst !== 5'd0 || alu_b !== 32'h0 || alu_a !== 32'h0)
            begin errors++; $display("FAIL reset_data ctr=%b dst=%0d a=%h b=%h exp=0", alu_ctr, ex_dst, alu_a, alu_b); end
        idle_id();
        step();
        rst_n = 1;
    endtask

    task automatic test_imm();
        idle_id();
        id_valid = 1; id_alu_ctr = 3'b010; id_alu_src = 1; id_imm16 = 16'h8001; id_rt = 5'd4; id_reg_write = 1;
        step();
        checks++; if (alu_b !== 32'h0000_8001) begin errors++; $display("FAIL imm_ori alu_b=%h exp=00008001", alu_b); end
        checks++; if (alu_ctr !== 3'b010 || ex_dst !== 5'd4) begin errors++; $display("FAIL ori_ctrl ctr=%b dst=%0d exp=010/4", alu_ctr, ex_dst); end
        id_alu_ctr = 3'b110; id_imm16 = 16'h1234;
        step();
        checks++; if (alu_b !== 32'h1234_0000) begin errors++; $display("FAIL imm_lui alu_b=%h exp=12340000", alu_b); end
        drive_load(5'd1, 5'd9, 16'hFFFC);
        step();
        idle_id();
        checks++; if (alu_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_load alu_b=%h exp=fffffffc", alu_b); end
        checks++; if (ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_valid !== 1'b1)
            begin errors++; $display("FAIL load_ctrl mr=%b m2r=%b v=%b exp=1", ex_mem_read, ex_mem_to_reg, ex_valid); end
        step();
    endtask

    task automatic test_forward();
        clear_bypass();
        drive_addu(5'd5, 5'd6, 5'd7, 32'h1111, 32'h2222, 1'b1);
        step();
        idle_id();
        checks++; if (alu_a !== 32'h1111 || alu_b !== 32'h2222 || ex_dst !== 5'd7)
            begin errors++; $display("FAIL fwd_none a=%h b=%h dst=%0d exp=1111/2222/7", alu_a, alu_b, ex_dst); end
        exm_reg_write = 1; exm_dst = 5'd5; exm_result = 32'hAAAA;
        wb_reg_write = 1; wb_dst = 5'd5; wb_data = 32'hBBBB;
        #1;
        checks++; if (alu_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_prio alu_a=%h exp=0000aaaa", alu_a); end
        exm_dst = 5'd0;
        #1;
        checks++; if (alu_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_wb alu_a=%h exp=0000bbbb", alu_a); end
        wb_dst = 5'd6;
        #1;
        checks++; if (alu_a !== 32'h1111 || alu_b !== 32'hBBBB || ex_store_data !== 32'hBBBB)
            begin errors++; $display("FAIL fwd_rt a=%h b=%h sd=%h exp=1111/bbbb/bbbb", alu_a, alu_b, ex_store_data); end
        // regfile write in the same cycle as the ID read
        drive_addu(5'd9, 5'd10, 5'd11, 32'h1, 32'h2, 1'b1);
        exm_reg_write = 0; wb_reg_write = 1; wb_dst = 5'd9; wb_data = 32'hCAFE;
        step();
        clear_bypass();
        idle_id();
        #1;
        checks++; if (alu_a !== 32'hCAFE || alu_b !== 32'h2) begin errors++; $display("FAIL cap_bypass a=%h b=%h exp=cafe/2", alu_a, alu_b); end
        step();
    endtask

    task automatic test_load_use();
        clear_bypass();
        drive_load(5'd1, 5'd8, 16'h0000);
        step();
        drive_addu(5'd8, 5'd3, 5'd4, 32'h0, 32'h7, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall stall=%b exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL lu_bubble v=%b rw=%b stall=%b exp=0/0/0", ex_valid, ex_reg_write, stall); end
        wb_reg_write = 1; wb_dst = 5'd8; wb_data = 32'h55;
        step();
        clear_bypass();
        #1;
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h55 || alu_b !== 32'h7 || ex_dst !== 5'd4)
            begin errors++; $display("FAIL lu_capture v=%b a=%h b=%h dst=%0d exp=1/55/7/4", ex_valid, alu_a, alu_b, ex_dst); end
        drive_load(5'd1, 5'd8, 16'h0000);
        step();
        drive_addu(5'd3, 5'd8, 5'd4, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused stall=%b exp=0", stall); end
        id_uses_rt = 1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_used stall=%b exp=1", stall); end
        idle_id();
        step();
    endtask

    task automatic test_flush();
        idle_id();
        id_valid = 1; id_alu_ctr = 3'b100; id_alu_src = 1; id_mem_write = 1; id_rs = 5'd2; id_rt = 5'd3;
        id_rt_data = 32'h99; id_imm16 = 16'h0010; flush = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || alu_ctr !== 3'b000)
            begin errors++; $display("FAIL flush_bubble v=%b rw=%b mw=%b ctr=%b exp=0", ex_valid, ex_reg_write, ex_mem_write, alu_ctr); end
        flush = 0;
        step();
        checks++; if (ex_valid !== 1'b1 || ex_mem_write !== 1'b1 || ex_store_data !== 32'h99 || alu_b !== 32'h10)
            begin errors++; $display("FAIL store_capture v=%b mw=%b sd=%h b=%h exp=1/1/99/10", ex_valid, ex_mem_write, ex_store_data, alu_b); end
        // flush concurrent with a load-use stall
        drive_load(5'd1, 5'd12, 16'h0000);
        step();
        drive_addu(5'd12, 5'd0, 5'd13, 32'h0, 32'h0, 1'b1);
        flush = 1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall stall=%b exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble v=%b mr=%b exp=0", ex_valid, ex_mem_read); end
        idle_id();
        step();
    endtask

    task automatic test_reg0();
        clear_bypass();
        drive_addu(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b1);
        wb_reg_write = 1; wb_dst = 5'd0; wb_data = 32'h1234;
        step();
        idle_id();
        exm_reg_write = 1; exm_dst = 5'd0; exm_result = 32'hDEAD;
        #1;
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL reg0_fwd a=%h b=%h exp=0", alu_a, alu_b); end
        clear_bypass();
        drive_load(5'd1, 5'd0, 16'h0000);
        step();
        drive_addu(5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reg0_stall stall=%b exp=0", stall); end
        idle_id();
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_id();
        clear_bypass();
        #2;
        checks++; if (ex_valid !== 1'b0 || stall !== 1'b0 || alu_ctr !== 3'b000)
            begin errors++; $display("FAIL reset_init v=%b stall=%b ctr=%b exp=0", ex_valid, stall, alu_ctr); end
        step();
        rst_n = 1;
        step();
        test_reset();
        test_imm();
        test_forward();
        test_load_use();
        test_flush();
        test_reg0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
